// File: rtl/ram_multiport_sync_pkg.sv
// Shared definitions for the multi-port RAM: the clear/ready state encoding
// and the names for the two same-address collision behaviours.
package ram_multiport_sync_pkg;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_multiport_sync_read_port.sv
// One registered read port: collision bypass mux, then data and valid flops.
// Data holds its last value whenever no read is accepted.
module ram_multiport_sync_read_port
  import ram_multiport_sync_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int RD_MODE = 0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              hit;

  // wr_en arrives already qualified with busy, so only real writes can collide
  assign hit = wr_en && (wr_addr == rd_addr);

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (rd_en && !busy) begin
      valid_d = 1'b1;
      data_d  = (RD_MODE == WR_FIRST && hit) ? wr_data : mem_word;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/ram_multiport_sync.sv
// 1-write / NUM_RD-read RAM with registered reads, selectable collision mode
// and an optional zero-fill sweep of every word after reset.
module ram_multiport_sync
  import ram_multiport_sync_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int NUM_RD         = 2,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     signal_C,
  input  logic                     signal_R,
  input  logic                     signal_E,
  input  logic [ADDR_W-1:0]        signal_A,
  input  logic [DATA_W-1:0]        signal_D,
  input  logic [NUM_RD*ADDR_W-1:0] signal_1,
  input  logic [NUM_RD-1:0]        signal_V,
  output logic [NUM_RD*DATA_W-1:0] signal_2,
  output logic [NUM_RD-1:0]        signal_Q,
  output logic                     signal_K
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              busy;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy     = (state_q == ST_CLEAR);
  assign user_we  = signal_E & ~busy;
  assign signal_K = busy;

  // The sweep borrows the single write port; user writes are locked out meanwhile
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = user_we & ~signal_R;
    mem_wa  = signal_A;
    mem_wd  = signal_D;
    if (state_q == ST_CLEAR) begin
      mem_we = ~signal_R;
      mem_wa = cnt_q[ADDR_W-1:0];
      mem_wd = '0;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge signal_C) begin
    if (signal_R) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge signal_C) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = signal_1[gi*ADDR_W +: ADDR_W];

    ram_multiport_sync_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_MODE(RD_MODE)
    ) u_rd (
      .clk     (signal_C),
      .srst    (signal_R),
      .rd_en   (signal_V[gi]),
      .rd_addr (rd_addr),
      .mem_word(mem[rd_addr]),
      .wr_en   (user_we),
      .wr_addr (signal_A),
      .wr_data (signal_D),
      .busy    (busy),
      .rd_data (signal_2[gi*DATA_W +: DATA_W]),
      .rd_valid(signal_Q[gi])
    );
  end

endmodule
